// File: rtl/id_ex_alu_issue_pkg.sv
// Shared ALU control encodings, opcode constants and operand-source selects
// for the decode-to-execute issue path.
package HighLevelControl;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_OR   = 4'd2,
        ALU_AND  = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLTU = 4'd8,
        ALU_SLT  = 4'd9
    } aluOperation;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_IALU  = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {OPA_ZERO, OPA_RS1, OPA_PC} opASel;
    typedef enum logic [2:0] {OPB_ZERO, OPB_RS2, OPB_IMM_I, OPB_SHAMT, OPB_IMM_U} opBSel;

    // funct3 -> operation, ignoring the funct7 alternate (SUB/SRA) bit.
    function automatic aluOperation baseOp(input logic [2:0] f3);
        case (f3)
            3'b000:  baseOp = ALU_ADD;
            3'b001:  baseOp = ALU_SLL;
            3'b010:  baseOp = ALU_SLT;
            3'b011:  baseOp = ALU_SLTU;
            3'b100:  baseOp = ALU_XOR;
            3'b101:  baseOp = ALU_SRL;
            3'b110:  baseOp = ALU_OR;
            default: baseOp = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_ex_alu_issue_alu_decoder.sv
// Combinational RV32I ALU-subset decoder: operation, operand sources, legality.
module alu_decoder
    import HighLevelControl::*;
(
    input  logic [31:0] instr,
    output aluOperation aluOp,
    output opASel       aSel,
    output opBSel       bSel,
    output logic        illegal
);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];

    always_comb begin
        aluOp   = ALU_ADD;
        aSel    = OPA_ZERO;
        bSel    = OPB_ZERO;
        illegal = 1'b0;
        case (opc)
            OPC_RTYPE: begin
                aSel  = OPA_RS1;
                bSel  = OPB_RS2;
                aluOp = baseOp(f3);
                if (f7 == F7_ALT && f3 == 3'b000)      aluOp = ALU_SUB;
                else if (f7 == F7_ALT && f3 == 3'b101) aluOp = ALU_SRA;
                else if (f7 != F7_BASE)                illegal = 1'b1;
            end
            OPC_IALU: begin
                aSel  = OPA_RS1;
                bSel  = OPB_IMM_I;
                aluOp = baseOp(f3);
                if (f3 == 3'b001) begin
                    bSel = OPB_SHAMT;
                    if (f7 != F7_BASE) illegal = 1'b1;
                end else if (f3 == 3'b101) begin
                    bSel = OPB_SHAMT;
                    if (f7 == F7_ALT)       aluOp = ALU_SRA;
                    else if (f7 != F7_BASE) illegal = 1'b1;
                end
            end
            OPC_LUI: bSel = OPB_IMM_U;
            OPC_AUIPC: begin
                aSel = OPA_PC;
                bSel = OPB_IMM_U;
            end
            default: illegal = 1'b1;
        endcase
        // Illegal instructions issue as a harmless ADD of zeros.
        if (illegal) begin
            aluOp = ALU_ADD;
            aSel  = OPA_ZERO;
            bSel  = OPB_ZERO;
        end
    end
endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX pipeline register for the ALU: decode, operand forwarding and
// immediate selection in front of a single stall/flush-able register.
module id_ex_alu_issue
    import HighLevelControl::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             idValid,
    input  logic [31:0]      idInstr,
    input  logic [WIDTH-1:0] idPC,
    input  logic [WIDTH-1:0] rs1Data,
    input  logic [WIDTH-1:0] rs2Data,
    input  logic [1:0]       fwdSelA,
    input  logic [1:0]       fwdSelB,
    input  logic [WIDTH-1:0] exMemResult,
    input  logic [WIDTH-1:0] memWbResult,
    input  logic             stall,
    input  logic             flush,
    output aluOperation      ALUCtrl,
    output logic [WIDTH-1:0] ALUOpA,
    output logic [WIDTH-1:0] ALUOpB,
    output logic             exValid,
    output logic [4:0]       exRd,
    output logic             exRegWrite,
    output logic             exIllegal
);
    aluOperation      decOp;
    opASel            aSel;
    opBSel            bSel;
    logic             decIllegal;

    alu_decoder u_dec (
        .instr   (idInstr),
        .aluOp   (decOp),
        .aSel    (aSel),
        .bSel    (bSel),
        .illegal (decIllegal)
    );

    // Reserved select 2'b11 falls back to the register file.
    function automatic logic [WIDTH-1:0] fwdMux(input logic [1:0] sel, input logic [WIDTH-1:0] rf,
                                                 input logic [WIDTH-1:0] exm, input logic [WIDTH-1:0] mwb);
        case (sel)
            FWD_EXMEM: fwdMux = exm;
            FWD_MEMWB: fwdMux = mwb;
            default:   fwdMux = rf;
        endcase
    endfunction

    logic [WIDTH-1:0] opA_d, opB_d, opA_q, opB_q;
    logic [WIDTH-1:0] immI, immU, shamt;
    logic [4:0]       rd_d, rd_q;
    logic             regWr_d, regWr_q, valid_q, illegal_q;
    aluOperation      ctrl_q;

    assign immI  = WIDTH'($signed(idInstr[31:20]));
    assign immU  = WIDTH'($signed({idInstr[31:12], 12'b0}));
    assign shamt = WIDTH'(idInstr[24:20]);
    assign rd_d  = idInstr[11:7];
    assign regWr_d = !decIllegal && (rd_d != 5'd0);

    always_comb begin
        opA_d = '0;
        opB_d = '0;
        case (aSel)
            OPA_RS1: opA_d = fwdMux(fwdSelA, rs1Data, exMemResult, memWbResult);
            OPA_PC:  opA_d = idPC;
            default: opA_d = '0;
        endcase
        case (bSel)
            OPB_RS2:   opB_d = fwdMux(fwdSelB, rs2Data, exMemResult, memWbResult);
            OPB_IMM_I: opB_d = immI;
            OPB_SHAMT: opB_d = shamt;
            OPB_IMM_U: opB_d = immU;
            default:   opB_d = '0;
        endcase
    end

    // Bubble on reset, flush, or an unstalled cycle with no valid instruction.
    always_ff @(posedge clk) begin
        if (reset || flush || (!stall && !idValid)) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            regWr_q   <= 1'b0;
            rd_q      <= '0;
            ctrl_q    <= ALU_ADD;
            opA_q     <= '0;
            opB_q     <= '0;
        end else if (!stall) begin
            valid_q   <= 1'b1;
            illegal_q <= decIllegal;
            regWr_q   <= regWr_d;
            rd_q      <= rd_d;
            ctrl_q    <= decOp;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
        end
    end

    assign ALUCtrl    = ctrl_q;
    assign ALUOpA     = opA_q;
    assign ALUOpB     = opB_q;
    assign exValid    = valid_q;
    assign exRd       = rd_q;
    assign exRegWrite = regWr_q;
    assign exIllegal  = illegal_q;
endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Table-driven bench for id_ex_alu_issue with a queue scoreboard and
// hand-written stall/flush/reset sequences.
module tb_id_ex_alu_issue;
    import HighLevelControl::*;

    logic        clk = 1'b0;
    logic        reset, idValid, stall, flush;
    logic [31:0] idInstr, idPC, rs1Data, rs2Data, exMemResult, memWbResult;
    logic [1:0]  fwdSelA, fwdSelB;
    aluOperation ALUCtrl;
    logic [31:0] ALUOpA, ALUOpB;
    logic        exValid, exRegWrite, exIllegal;
    logic [4:0]  exRd;

    id_ex_alu_issue #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .idValid(idValid), .idInstr(idInstr), .idPC(idPC),
        .rs1Data(rs1Data), .rs2Data(rs2Data), .fwdSelA(fwdSelA), .fwdSelB(fwdSelB),
        .exMemResult(exMemResult), .memWbResult(memWbResult), .stall(stall), .flush(flush),
        .ALUCtrl(ALUCtrl), .ALUOpA(ALUOpA), .ALUOpB(ALUOpB), .exValid(exValid),
        .exRd(exRd), .exRegWrite(exRegWrite), .exIllegal(exIllegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        valid, illegal, regWr;
        logic [4:0]  rd;
        aluOperation ctrl;
        logic [31:0] opA, opB;
    } exp_t;

    typedef struct {
        logic        vld;
        logic [31:0] instr, pc, rs1, rs2, exm, mwb;
        logic [1:0]  fa, fb;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   nChecks = 0;
    int   nPass = 0;

    function automatic logic [31:0] rt(logic [6:0] f7, logic [4:0] r2, logic [4:0] r1, logic [2:0] f3, logic [4:0] rd);
        return {f7, r2, r1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] it(logic [11:0] imm, logic [4:0] r1, logic [2:0] f3, logic [4:0] rd);
        return {imm, r1, f3, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] ut(logic [19:0] imm, logic [4:0] rd, logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic exp_t mkE(string n, logic v, logic il, logic rw, logic [4:0] rd,
                                 aluOperation c, logic [31:0] a, logic [31:0] b);
        exp_t e;
        e.name = n; e.valid = v; e.illegal = il; e.regWr = rw; e.rd = rd; e.ctrl = c; e.opA = a; e.opB = b;
        return e;
    endfunction

    function automatic exp_t bubble(string n);
        return mkE(n, 1'b0, 1'b0, 1'b0, 5'd0, ALU_ADD, 32'd0, 32'd0);
    endfunction

    task automatic addv(logic vld, logic [31:0] instr, logic [31:0] pc, logic [31:0] r1, logic [31:0] r2,
                        logic [1:0] fa, logic [1:0] fb, logic [31:0] exm, logic [31:0] mwb, exp_t e);
        vec_t v;
        v.vld = vld; v.instr = instr; v.pc = pc; v.rs1 = r1; v.rs2 = r2;
        v.fa = fa; v.fb = fb; v.exm = exm; v.mwb = mwb; v.e = e;
        vecs.push_back(v);
    endtask

    task automatic apply(vec_t v);
        idValid = v.vld; idInstr = v.instr; idPC = v.pc; rs1Data = v.rs1; rs2Data = v.rs2;
        fwdSelA = v.fa; fwdSelB = v.fb; exMemResult = v.exm; memWbResult = v.mwb;
    endtask

    // Advance one edge, then pop the expected record and compare.
    task automatic stepCheck();
        exp_t e;
        @(posedge clk);
        #1;
        nChecks++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard-empty: DUT output with no expectation");
            return;
        end
        e = sb.pop_front();
        if (exValid === e.valid && exIllegal === e.illegal && exRegWrite === e.regWr && exRd === e.rd &&
            ALUCtrl === e.ctrl && ALUOpA === e.opA && ALUOpB === e.opB)
            nPass++;
        else
            $display("FAIL %s: got v=%b il=%b rw=%b rd=%0d ctrl=%0d A=%h B=%h, want v=%b il=%b rw=%b rd=%0d ctrl=%0d A=%h B=%h",
                     e.name, exValid, exIllegal, exRegWrite, exRd, ALUCtrl, ALUOpA, ALUOpB,
                     e.valid, e.illegal, e.regWr, e.rd, e.ctrl, e.opA, e.opB);
    endtask

    initial begin
        vec_t v;
        addv(1, rt(7'h20, 2, 1, 3'd0, 3), 0, 10, 3, 0, 0, 0, 0, mkE("sub", 1, 0, 1, 3, ALU_SUB, 10, 3));
        addv(1, it(12'hFFF, 1, 3'd0, 5), 0, 5, 0, 0, 0, 0, 0, mkE("addi-neg", 1, 0, 1, 5, ALU_ADD, 5, 32'hFFFF_FFFF));
        addv(1, it({7'h20, 5'd4}, 1, 3'd5, 6), 0, 32'h80, 0, 0, 0, 0, 0, mkE("srai", 1, 0, 1, 6, ALU_SRA, 32'h80, 4));
        addv(1, ut(20'h12345, 7, 7'b0010111), 32'h100, 9, 9, 0, 0, 0, 0, mkE("auipc", 1, 0, 1, 7, ALU_ADD, 32'h100, 32'h1234_5000));
        addv(1, ut(20'hABCDE, 8, 7'b0110111), 32'h200, 99, 98, 0, 0, 0, 0, mkE("lui", 1, 0, 1, 8, ALU_ADD, 0, 32'hABCD_E000));
        addv(1, rt(7'h00, 2, 1, 3'd0, 9), 0, 0, 1, 2'b01, 2'b10, 32'hDEAD, 7, mkE("fwd", 1, 0, 1, 9, ALU_ADD, 32'hDEAD, 7));
        addv(1, rt(7'h00, 2, 1, 3'd4, 10), 0, 32'h55, 32'hF0, 2'b11, 2'b11, 1, 2, mkE("fwd-rsvd", 1, 0, 1, 10, ALU_XOR, 32'h55, 32'hF0));
        addv(1, {12'h0, 5'd1, 3'b010, 5'd11, 7'b0000011}, 0, 4, 4, 0, 0, 0, 0, mkE("load-illegal", 1, 1, 0, 11, ALU_ADD, 0, 0));
        addv(1, rt(7'h01, 2, 1, 3'd0, 12), 0, 4, 4, 0, 0, 0, 0, mkE("mul-illegal", 1, 1, 0, 12, ALU_ADD, 0, 0));
        addv(1, rt(7'h00, 2, 1, 3'd0, 0), 0, 1, 2, 0, 0, 0, 0, mkE("rd0", 1, 0, 0, 0, ALU_ADD, 1, 2));
        addv(0, rt(7'h20, 2, 1, 3'd0, 3), 0, 10, 3, 0, 0, 0, 0, bubble("idvalid0"));
        addv(1, it(12'h800, 1, 3'd3, 13), 0, 3, 0, 0, 0, 0, 0, mkE("sltiu", 1, 0, 1, 13, ALU_SLTU, 3, 32'hFFFF_F800));
        addv(1, it({7'h20, 5'd1}, 1, 3'd1, 14), 0, 3, 0, 0, 0, 0, 0, mkE("slli-bad", 1, 1, 0, 14, ALU_ADD, 0, 0));
        addv(1, rt(7'h00, 2, 1, 3'd5, 15), 0, 32'h100, 4, 0, 0, 0, 0, mkE("srl", 1, 0, 1, 15, ALU_SRL, 32'h100, 4));
        addv(1, rt(7'h00, 2, 1, 3'd2, 16), 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, mkE("slt", 1, 0, 1, 16, ALU_SLT, 32'hFFFF_FFFF, 1));
        addv(1, it(12'h0F0, 1, 3'd6, 17), 0, 32'h0F, 0, 0, 0, 0, 0, mkE("ori", 1, 0, 1, 17, ALU_OR, 32'h0F, 32'hF0));
        addv(1, rt(7'h00, 2, 1, 3'd7, 18), 0, 32'hFF, 32'h3C, 0, 0, 0, 0, mkE("and", 1, 0, 1, 18, ALU_AND, 32'hFF, 32'h3C));
        addv(1, it({7'h00, 5'd3}, 1, 3'd1, 19), 0, 1, 0, 0, 0, 0, 0, mkE("slli", 1, 0, 1, 19, ALU_SLL, 1, 3));
        addv(1, rt(7'h20, 2, 1, 3'd1, 20), 0, 1, 1, 0, 0, 0, 0, mkE("sll-f7alt-bad", 1, 1, 0, 20, ALU_ADD, 0, 0));

        // Reset with a valid instruction presented: must still be a bubble.
        reset = 1; stall = 0; flush = 0;
        apply(vecs[0]);
        sb.push_back(bubble("reset"));
        stepCheck();
        reset = 0;

        foreach (vecs[i]) begin
            apply(vecs[i]);
            sb.push_back(vecs[i].e);
            stepCheck();
        end

        // Load, then hold through three stalls while the input keeps changing.
        apply(vecs[0]);
        sb.push_back(vecs[0].e);
        stepCheck();
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            v = vecs[k + 1];
            apply(v);
            sb.push_back(mkE($sformatf("stall-hold%0d", k), 1, 0, 1, 3, ALU_SUB, 10, 3));
            stepCheck();
        end
        flush = 1;
        sb.push_back(bubble("stall+flush"));
        stepCheck();
        flush = 0; stall = 0;

        // Reset during a stall discards the held instruction; next edge loads.
        apply(vecs[2]);
        sb.push_back(vecs[2].e);
        stepCheck();
        stall = 1;
        apply(vecs[3]);
        sb.push_back(vecs[2].e);
        stepCheck();
        reset = 1;
        sb.push_back(bubble("reset-in-stall"));
        stepCheck();
        reset = 0; stall = 0;
        apply(vecs[3]);
        sb.push_back(vecs[3].e);
        stepCheck();

        // Flush alone against a valid load.
        flush = 1;
        apply(vecs[5]);
        sb.push_back(bubble("flush"));
        stepCheck();
        flush = 0;

        if (sb.size() != 0) begin
            nChecks++;
            $display("FAIL scoreboard-leftover: %0d entries remain, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
